// File: rtl/adder_wide_seq.sv
// Multi-word add/subtract that reuses one 32-bit carry-select adder, LSW first; done pulses WORDS cycles after start.
// There is no backpressure: start is taken only in IDLE or DONE, and the result is held in s/co/ovf until the next completion.

module adder_32bits (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_ci,
    output logic [31:0] o_s,
    output logic        o_co
);
    logic [16:0] w_lo;
    logic [16:0] w_hi0;
    logic [16:0] w_hi1;

    // The upper half is computed for both carry-ins in parallel; the lower carry selects one.
    assign w_lo  = {1'b0, i_a[15:0]}  + {1'b0, i_b[15:0]}  + {16'd0, i_ci};
    assign w_hi0 = {1'b0, i_a[31:16]} + {1'b0, i_b[31:16]};
    assign w_hi1 = {1'b0, i_a[31:16]} + {1'b0, i_b[31:16]} + 17'd1;

    assign o_s  = {(w_lo[16] ? w_hi1[15:0] : w_hi0[15:0]), w_lo[15:0]};
    assign o_co = w_lo[16] ? w_hi1[16] : w_hi0[16];
endmodule

module adder_wide_seq #(
    parameter int WORDS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [32*WORDS-1:0] a,
    input  logic [32*WORDS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [32*WORDS-1:0] s,
    output logic                co,
    output logic                ovf
);
    localparam int W    = 32 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic            r_carry;
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_s;
    logic            r_co;
    logic            r_ovf;

    logic            w_accept;
    logic [IDXW+4:0] w_base;
    logic [31:0]     w_sum;
    logic            w_co;
    logic [W-1:0]    w_result;
    logic            w_ovf;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_base   = {r_idx, 5'd0};

    adder_32bits u_add (
        .i_a  (r_opa[w_base +: 32]),
        .i_b  (r_opb[w_base +: 32]),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // Full result as it will look once the current word lands; only published on the last word.
    always_comb begin
        w_result = r_work;
        w_result[w_base +: 32] = w_sum;
    end

    // r_opb already holds ~b for subtraction, so one rule covers both operations.
    assign w_ovf = (r_opa[W-1] == r_opb[W-1]) && (w_sum[31] != r_opa[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_opa   <= '0;
            r_opb   <= '0;
            r_work  <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_work[w_base +: 32] <= w_sum;
                    r_carry <= w_co;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                        r_s     <= w_result;
                        r_co    <= w_co;
                        r_ovf   <= w_ovf;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_accept) begin
                r_state <= S_RUN;
                r_opa   <= a;
                r_opb   <= sub ? ~b : b;
                r_carry <= sub;
                r_idx   <= '0;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign s    = r_s;
    assign co   = r_co;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_adder_wide_seq.sv
// Directed and random add/subtract sequences for adder_wide_seq, checked against a plain-arithmetic model.
module tb_adder_wide_seq;
    localparam int WORDS = 2;
    localparam int W     = 32 * WORDS;
    localparam int LIMIT = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    adder_wide_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: full-width two's-complement arithmetic.
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                         output logic [W-1:0] es, output logic eco, output logic eovf);
        logic [W:0] wide;
        if (!tsub) begin
            wide = {1'b0, ta} + {1'b0, tb};
            es   = wide[W-1:0];
            eco  = wide[W];
            eovf = (ta[W-1] == tb[W-1]) && (es[W-1] != ta[W-1]);
        end else begin
            es   = ta - tb;
            eco  = (ta >= tb);
            eovf = (ta[W-1] != tb[W-1]) && (es[W-1] != ta[W-1]);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Called on the negedge right after start was sampled; returns on the negedge where done is seen.
    task automatic wait_done(input string tag, output int cyc, output int nbusy);
        cyc = 0;
        nbusy = 0;
        while (!done && cyc < LIMIT) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, W'(cyc < LIMIT), W'(1));
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub);
        logic [W-1:0] es;
        logic eco, eovf;
        model(ta, tb, tsub, es, eco, eovf);
        chk({tag, "_s"}, s, es);
        chk({tag, "_co"}, W'(co), W'(eco));
        chk({tag, "_ovf"}, W'(ovf), W'(eovf));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub);
        int cyc, nb;
        @(negedge clk);
        a = ta; b = tb; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
        wait_done(tag, cyc, nb);
        chk({tag, "_busy_cycles"}, W'(nb), W'(WORDS));
        check_result(tag, ta, tb, tsub);
        @(negedge clk);
        chk({tag, "_done_pulse"}, W'(done), W'(0));
    endtask

    initial begin
        int cyc, nb;
        logic [W-1:0] ra, rb;
        logic rs;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_s", s, W'(0));
        chk("rst_co", W'(co), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));
        rst = 1'b0;

        run_op("carry_mid", 64'h00000000_FFFFFFFF, 64'h1, 1'b0);
        chk("carry_mid_exact", s, 64'h00000001_00000000);
        run_op("carry_wrap", 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0);
        chk("carry_wrap_co", W'(co), W'(1));
        run_op("sub_borrow", 64'h5, 64'h7, 1'b1);
        chk("sub_borrow_exact", s, 64'hFFFFFFFF_FFFFFFFE);
        run_op("sub_pos", 64'h7, 64'h5, 1'b1);
        chk("sub_pos_exact", s, 64'h2);
        run_op("add_ovf", 64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0);
        chk("add_ovf_flag", W'(ovf), W'(1));
        run_op("sub_ovf", 64'h80000000_00000000, 64'h1, 1'b1);
        chk("sub_ovf_exact", s, 64'h7FFFFFFF_FFFFFFFF);

        // start pulsed again during RUN with different operands must be ignored
        @(negedge clk);
        a = 64'h12345678_9ABCDEF0; b = 64'h0FEDCBA9_87654321; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 64'hFFFF0000_FFFF0000; b = 64'h1111; sub = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore", cyc, nb);
        check_result("ignore", 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0);
        @(negedge clk);
        chk("ignore_no_restart", W'(busy | done), W'(0));

        // back-to-back: start held in the DONE cycle
        @(negedge clk);
        a = 64'hDEADBEEF_00000010; b = 64'h00000001_00000020; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_first", cyc, nb);
        check_result("b2b_first", 64'hDEADBEEF_00000010, 64'h00000001_00000020, 1'b0);
        a = 64'h00000003_00000001; b = 64'h00000001_00000002; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", W'(busy), W'(1));
        wait_done("b2b_second", cyc, nb);
        chk("b2b_gap", W'(cyc + 1), W'(WORDS + 1));
        check_result("b2b_second", 64'h00000003_00000001, 64'h00000001_00000002, 1'b1);

        // reset on the first RUN cycle: outputs clear asynchronously
        @(negedge clk);
        a = 64'hFFFFFFFF_FFFFFFFF; b = 64'hFFFFFFFF_FFFFFFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        chk("rst_mid_pre_busy", W'(busy), W'(1));
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", W'(busy), W'(0));
        chk("rst_mid_done", W'(done), W'(0));
        chk("rst_mid_s", s, W'(0));
        chk("rst_mid_co", W'(co), W'(0));
        chk("rst_mid_ovf", W'(ovf), W'(0));
        @(negedge clk);
        chk("rst_hold_start_ignored", W'(busy), W'(0));
        start = 1'b0;
        rst = 1'b0;
        run_op("after_rst", 64'h3, 64'h4, 1'b0);
        chk("after_rst_exact", s, 64'h7);

        for (int i = 0; i < 16; i++) begin
            ra = rand_op();
            rb = (i % 4 == 0) ? ra : rand_op();
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), ra, rb, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
